// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the sequential restoring divider:
//   - FSM state encoding (2-bit): IDLE, RUN, ZERO, DONE
//   - default operand widths
//   - helper for the divide-by-zero quotient pattern
// No ports; imported by seq_divider and div_step.
// -----------------------------------------------------------------------------
package seq_divider_pkg;

    // Default widths: dividend/quotient match the register/ALU path,
    // divisor/remainder match the switch operand.
    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Quotient reported for a zero divisor (all ones, 8'hFF at the default width).
    localparam logic [DEF_DIVIDEND_W-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
// The partial remainder is shifted left with the next dividend bit entering
// at the bottom; the divisor is then trial-subtracted with a ripple-carry
// adder (shifted + ~divisor + 1). The adder carry-out is the quotient bit:
// set means shifted >= divisor and the difference is kept, clear means the
// shifted value is restored.
//
// Ports:
//   p_in         in   DIVISOR_W+1  current partial remainder
//   dividend_bit in   1            next dividend bit (MSB first)
//   divisor      in   DIVISOR_W    non-zero divisor
//   p_out        out  DIVISOR_W+1  next partial remainder
//   q_bit        out  1            quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import seq_divider_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   p_in,
    input  logic                 dividend_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   p_out,
    output logic                 q_bit
);

    localparam int P_W = DIVISOR_W + 1;

    logic [P_W-1:0] shifted;
    logic [P_W-1:0] divisor_inv;
    logic [P_W-1:0] diff;
    logic [P_W:0]   carry;

    // The partial remainder is always below the divisor, so its top bit is
    // zero on entry and the shift never loses information.
    logic unused_p_msb;
    assign unused_p_msb = p_in[P_W-1];

    assign shifted     = {p_in[P_W-2:0], dividend_bit};
    assign divisor_inv = ~{1'b0, divisor};

    always_comb begin
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < P_W; i++) begin
            diff[i]    = shifted[i] ^ divisor_inv[i] ^ carry[i];
            carry[i+1] = (shifted[i] & divisor_inv[i]) |
                         (carry[i] & (shifted[i] ^ divisor_inv[i]));
        end
    end

    assign q_bit = carry[P_W];
    assign p_out = q_bit ? diff : shifted;

endmodule : div_step

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle unsigned restoring divider (inverse of the ALU multiply).
// A start in IDLE latches the operands; a non-zero divisor runs DIVIDEND_W
// restoring steps (one per clock) and a zero divisor takes a short fixed path
// that reports quotient all-ones with div_by_zero set. done pulses for one
// cycle in DONE; results stay registered until the next result load.
//
// Ports:
//   clk          in   1           system clock, rising edge
//   reset        in   1           asynchronous, active-high reset
//   start        in   1           request a division, sampled only in IDLE
//   dividend     in   DIVIDEND_W  numerator, captured on the accepting edge
//   divisor      in   DIVISOR_W   denominator, captured on the accepting edge
//   busy         out  1           high whenever the state is not IDLE
//   done         out  1           one-cycle pulse, results valid
//   quotient     out  DIVIDEND_W  registered quotient
//   remainder    out  DIVISOR_W   registered remainder
//   div_by_zero  out  1           registered flag for the last operation
// -----------------------------------------------------------------------------
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam int P_W   = DIVISOR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W);

    div_state_t state;
    div_state_t state_next;

    logic [CNT_W-1:0]      count;
    logic [P_W-1:0]        part_rem;
    // Dividend bits leave at the top while quotient bits enter at the bottom;
    // after DIVIDEND_W steps the register holds the complete quotient.
    logic [DIVIDEND_W-1:0] dq;
    logic [DIVISOR_W-1:0]  dvsr;

    logic [P_W-1:0]        p_next;
    logic                  q_bit;
    logic                  accept;
    logic                  last_step;

    assign accept    = (state == IDLE) && start;
    assign last_step = (state == RUN) && (count == CNT_ONE);

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .p_in         (part_rem),
        .dividend_bit (dq[DIVIDEND_W-1]),
        .divisor      (dvsr),
        .p_out        (p_next),
        .q_bit        (q_bit)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (divisor == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                if (count == CNT_ONE) begin
                    state_next = DONE;
                end
            end
            // The counter holds one extra wait edge so the zero path
            // finishes two edges after acceptance.
            ZERO: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Working registers: operands, counter, partial remainder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            part_rem <= '0;
            dq       <= '0;
            dvsr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dq       <= dividend;
                        dvsr     <= divisor;
                        part_rem <= '0;
                        count    <= (divisor == '0) ? CNT_ONE : CNT_LOAD;
                    end
                end
                RUN: begin
                    dq       <= {dq[DIVIDEND_W-2:0], q_bit};
                    part_rem <= p_next;
                    count    <= count - CNT_ONE;
                end
                ZERO: begin
                    if (count != '0) begin
                        count <= count - CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers change only on a result-load edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (last_step) begin
            quotient    <= {dq[DIVIDEND_W-2:0], q_bit};
            // Final partial remainder is below the divisor, so it fits.
            remainder   <= p_next[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
        end else if ((state == ZERO) && (count == '0)) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
        end
    end

    // The top partial-remainder bit is zero once a step completes.
    logic unused_p_next_msb;
    assign unused_p_next_msb = p_next[P_W-1];

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed bench for seq_divider: reset values, hand-computed quotients,
// divide by zero, start held through a run, mid-run reset, and an exhaustive
// sweep of non-zero divisors checked against the division identity.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_checks;
    int n_fail;

    seq_divider dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge. Presents one request, returns
    // the number of edges from the accepting edge to the first cycle with
    // done high (-1 on timeout).
    task automatic run_div(input logic [7:0] a, input logic [3:0] b, output int lat);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat,
                                input logic [7:0] q, input logic [3:0] r, input logic z);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_q"},   quotient, q);
        check({tag, "_r"},   remainder, r);
        check({tag, "_dbz"}, div_by_zero, z);
    endtask

    initial begin
        int lat;
        int pulses;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q",    quotient, 0);
        check("rst_r",    remainder, 0);
        check("rst_dbz",  div_by_zero, 0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 200 / 7 = 28 r 4, with busy high during the run
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            check("busy_running", busy, 1);
        end
        check_result("d200_7", lat, 8, 8'd28, 4'd4, 1'b0);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("idle_not_busy", busy, 0);
        check("hold_q", quotient, 28);

        run_div(8'd255, 4'd1, lat);
        check_result("d255_1", lat, 8, 8'd255, 4'd0, 1'b0);
        @(posedge clk);
        #1;

        run_div(8'd5, 4'd9, lat);
        check_result("d5_9", lat, 8, 8'd0, 4'd5, 1'b0);
        @(posedge clk);
        #1;

        run_div(8'd100, 4'd0, lat);
        check_result("d100_0", lat, 2, 8'hFF, 4'd0, 1'b1);
        @(posedge clk);
        #1;

        run_div(8'd9, 4'd3, lat);
        check_result("d9_3", lat, 8, 8'd3, 4'd0, 1'b0);
        @(posedge clk);
        #1;

        // start held high; operands change after the third run edge
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(posedge clk);
        #1;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) begin
                dividend = 8'd50;
                divisor  = 4'd5;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        check_result("hold_first", lat, 8, 8'd28, 4'd4, 1'b0);
        @(posedge clk);
        #1;
        check("hold_idle_busy", busy, 0);
        @(posedge clk);
        #1;
        check("hold_second_accept", busy, 1);
        start = 1'b0;
        lat   = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check_result("hold_second", lat, 8, 8'd10, 4'd0, 1'b0);
        @(posedge clk);
        #1;

        // zero-divide first so the flag is set before the aborted run
        run_div(8'd1, 4'd0, lat);
        check_result("pre_abort", lat, 2, 8'hFF, 4'd0, 1'b1);
        @(posedge clk);
        #1;

        // reset in cycle 4 of a 200/7 run
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q",    quotient, 0);
        check("abort_r",    remainder, 0);
        check("abort_dbz",  div_by_zero, 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);

        run_div(8'd225, 4'd15, lat);
        check_result("d225_15", lat, 8, 8'd15, 4'd0, 1'b0);
        @(posedge clk);
        #1;

        // every dividend against every non-zero divisor
        for (int b = 1; b < 16; b++) begin
            for (int a = 0; a < 256; a++) begin
                run_div(a[7:0], b[3:0], lat);
                check("sweep_lat", lat, 8);
                check("sweep_identity", int'(quotient) * b + int'(remainder), a);
                check("sweep_rem_lt", (int'(remainder) < b) ? 1 : 0, 1);
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_divider
